// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Multi-cycle binary-to-BCD converter. It uses a serial double-dabble
// datapath that does one shift per clock. A signed input is converted as a
// sign plus a magnitude. The block also reports leading-zero blanking and
// overflow.
//
// Parameters
//   WIDTH   width of the binary input (>= 2)
//   DIGITS  number of BCD output digits
//   SIGNED  1: bin is two's complement, 0: bin is unsigned
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request strobe, only honoured while ready = 1
//   bin      value to convert, sampled on the accepting edge
//   ready    idle and able to accept start
//   valid    one-cycle pulse marking a new result
//   bcd      result digits, digit 0 in bcd[3:0]
//   bcd_sgn  sign code: 4'b1010 = minus, 4'b1111 = blank
//   blank    bit i set when digit i is a leading zero
//   ovf      magnitude did not fit in DIGITS digits
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            bcd_sgn,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0]        SGN_MINUS = 4'b1010;
  localparam logic [3:0]        SGN_BLANK = 4'b1111;
  // After reset the display shows a single "0", so digit 0 is never blanked.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       work_q, work_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          sgn_pend_q, sgn_pend_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [3:0]          bcd_sgn_q, bcd_sgn_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;

  logic                accept;
  logic                last_shift;
  logic                neg_in;
  logic [BW-1:0]       work_corr;
  logic [BW-1:0]       work_shift;
  logic                shift_out;

  // A digit is a leading zero when it and every higher digit are zero.
  // Overflow shows all digits, because the truncated value would mislead.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] v,
                                                 input logic         o);
    logic zero_above;
    blank_of   = '0;
    zero_above = 1'b1;
    // NOTE: a function body is combinational scratch work, so it uses blocking
    // assignments. Only the always_ff blocks use non-blocking assignments.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (v[4*i +: 4] == 4'd0);
      blank_of[i] = zero_above && !o;
    end
  endfunction

  assign accept     = (state_q == S_IDLE) && start;
  assign last_shift = (state_q == S_CONV) && (cnt_q == CW'(1));
  assign neg_in     = (SIGNED != 0) && bin[WIDTH-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first. An incomplete branch then
    // holds that default instead of inferring a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)      state_d = S_CONV;
      S_CONV: if (last_shift) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next-values
  // ---------------------------------------------------------------------------
  // Double-dabble step: add 3 to every digit >= 5, then shift one bit left.
  // The correction runs on all digits in parallel before the shift.
  always_comb begin
    work_corr = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) work_corr[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  assign work_shift = {work_corr[BW-2:0], mag_q[WIDTH-1]};
  assign shift_out  = work_corr[BW-1];

  always_comb begin
    work_d     = work_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sgn_pend_d = sgn_pend_q;
    ovf_acc_d  = ovf_acc_q;
    bcd_d      = bcd_q;
    bcd_sgn_d  = bcd_sgn_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    if (accept) begin
      // The most negative input gives a magnitude of 2^(WIDTH-1), which
      // still fits because the magnitude is treated as unsigned.
      mag_d      = neg_in ? (~bin + WIDTH'(1)) : bin;
      sgn_pend_d = neg_in ? SGN_MINUS : SGN_BLANK;
      work_d     = '0;
      ovf_acc_d  = 1'b0;
      cnt_d      = CW'(WIDTH);
    end else if (state_q == S_CONV) begin
      work_d    = work_shift;
      mag_d     = {mag_q[WIDTH-2:0], 1'b0};
      ovf_acc_d = ovf_acc_q | shift_out;
      cnt_d     = cnt_q - CW'(1);
      if (last_shift) begin
        bcd_d     = work_shift;
        bcd_sgn_d = sgn_pend_q;
        ovf_d     = ovf_acc_q | shift_out;
        blank_d   = blank_of(work_shift, ovf_acc_q | shift_out);
        valid_d   = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // Reset clears the working state as well as the outputs. A conversion that
  // is aborted by reset therefore leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q     <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      sgn_pend_q <= SGN_BLANK;
      ovf_acc_q  <= 1'b0;
      bcd_q      <= '0;
      bcd_sgn_q  <= SGN_BLANK;
      blank_q    <= BLANK_RST;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      work_q     <= work_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      sgn_pend_q <= sgn_pend_d;
      ovf_acc_q  <= ovf_acc_d;
      bcd_q      <= bcd_d;
      bcd_sgn_q  <= bcd_sgn_d;
      blank_q    <= blank_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign valid   = valid_q;
  assign bcd     = bcd_q;
  assign bcd_sgn = bcd_sgn_q;
  assign blank   = blank_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq. It runs three instances in lockstep:
//   u_s5: signed input, 5 digits
//   u_u5: unsigned input, 5 digits
//   u_u3: unsigned input, 3 digits (exercises overflow)
// The bench pushes expected results into a per-instance queue when a request
// is accepted. Independent monitors pop the queue and compare on every valid
// pulse.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin;

  logic        rdy_s5, v_s5, ovf_s5;
  logic [19:0] bcd_s5;
  logic [3:0]  sgn_s5;
  logic [4:0]  blk_s5;

  logic        rdy_u5, v_u5, ovf_u5;
  logic [19:0] bcd_u5;
  logic [3:0]  sgn_u5;
  logic [4:0]  blk_u5;

  logic        rdy_u3, v_u3, ovf_u3;
  logic [11:0] bcd_u3;
  logic [3:0]  sgn_u3;
  logic [2:0]  blk_u3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_valid_s5 = -1;
  bit period_chk    = 1'b0;

  typedef struct packed {
    logic [19:0] bcd;
    logic [3:0]  sgn;
    logic [4:0]  blank;
    logic        ovf;
  } exp_t;

  typedef struct {
    exp_t e;
    int   acc;
  } item_t;

  item_t q_s5[$];
  item_t q_u5[$];
  item_t q_u3[$];

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u_s5 (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .ready(rdy_s5), .valid(v_s5),
    .bcd(bcd_s5), .bcd_sgn(sgn_s5), .blank(blk_s5), .ovf(ovf_s5));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_u5 (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .ready(rdy_u5), .valid(v_u5),
    .bcd(bcd_u5), .bcd_sgn(sgn_u5), .blank(blk_u5), .ovf(ovf_u5));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(3), .SIGNED(0)) u_u3 (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .ready(rdy_u3), .valid(v_u3),
    .bcd(bcd_u3), .bcd_sgn(sgn_u3), .blank(blk_u3), .ovf(ovf_u3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model. It works on the decimal value of the magnitude with
  // plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] b, input bit sgn_mode, input int digits);
    exp_t r;
    int   mag, lim, v, p;
    bit   neg;
    neg = sgn_mode && b[15];
    mag = neg ? 65536 - int'(b) : int'(b);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    r       = '0;
    r.sgn   = neg ? 4'b1010 : 4'b1111;
    r.ovf   = (mag >= lim);
    v       = mag % lim;
    p       = 1;
    for (int i = 0; i < digits; i++) begin
      r.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
      r.blank[i] = !r.ovf && (i > 0) && (mag < p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare(input string tag, input logic [19:0] b, input logic [3:0] s,
                         input logic [4:0] bl, input logic o, input item_t it);
    check({tag, "_bcd"},   32'(b),  32'(it.e.bcd));
    check({tag, "_sgn"},   32'(s),  32'(it.e.sgn));
    check({tag, "_blank"}, 32'(bl), 32'(it.e.blank));
    check({tag, "_ovf"},   32'(o),  32'(it.e.ovf));
    check({tag, "_latency"}, 32'(cyc - it.acc), 32'd16);
  endtask

  task automatic spurious(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s_unexpected_valid: got valid with empty queue (cycle %0d)", tag, cyc);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (v_s5) begin
      if (q_s5.size() == 0) spurious("s5");
      else compare("s5", bcd_s5, sgn_s5, blk_s5, ovf_s5, q_s5.pop_front());
      if (period_chk && last_valid_s5 >= 0)
        check("s5_period", 32'(cyc - last_valid_s5), 32'd17);
      last_valid_s5 = cyc;
    end
  end

  always @(negedge clk) begin
    if (v_u5) begin
      if (q_u5.size() == 0) spurious("u5");
      else compare("u5", bcd_u5, sgn_u5, blk_u5, ovf_u5, q_u5.pop_front());
    end
  end

  always @(negedge clk) begin
    if (v_u3) begin
      if (q_u3.size() == 0) spurious("u3");
      else compare("u3", 20'(bcd_u3), sgn_u3, 5'(blk_u3), ovf_u3, q_u3.pop_front());
    end
  end

  task automatic push_exp(input logic [15:0] b);
    q_s5.push_back('{e: model(b, 1'b1, 5), acc: cyc});
    q_u5.push_back('{e: model(b, 1'b0, 5), acc: cyc});
    q_u3.push_back('{e: model(b, 1'b0, 3), acc: cyc});
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!rdy_s5 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_timeout", 32'(rdy_s5), 32'd1);
  endtask

  // Issue one request. The caller is positioned just after a rising edge.
  task automatic send(input logic [15:0] b);
    wait_ready();
    bin   = b;
    start = 1'b1;
    @(posedge clk); #1;
    push_exp(b);
    start = 1'b0;
    bin   = 16'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q_s5.size() != 0 || q_u5.size() != 0 || q_u3.size() != 0) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", 32'(q_s5.size() + q_u5.size() + q_u3.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s5_ready"}, 32'(rdy_s5), 32'd1);
    check({tag, "_s5_valid"}, 32'(v_s5),   32'd0);
    check({tag, "_s5_bcd"},   32'(bcd_s5), 32'd0);
    check({tag, "_s5_sgn"},   32'(sgn_s5), 32'hF);
    check({tag, "_s5_blank"}, 32'(blk_s5), 32'h1E);
    check({tag, "_s5_ovf"},   32'(ovf_s5), 32'd0);
    check({tag, "_u3_blank"}, 32'(blk_u3), 32'h6);
    check({tag, "_u3_ready"}, 32'(rdy_u3), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed values.
    send(16'hFFFF); wait_idle();
    send(16'h8000); wait_idle();
    send(16'd0);    wait_idle();
    send(16'd407);  wait_idle();
    send(16'd1234); wait_idle();
    send(16'd999);  wait_idle();
    send(16'd9);    wait_idle();
    send(16'd10);   wait_idle();

    // A start while busy is dropped. Only the first value comes out.
    send(16'd4321);
    repeat (4) @(posedge clk);
    #1;
    check("busy_ready", 32'(rdy_s5), 32'd0);
    bin   = 16'd777;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Back-to-back: start held high, one result every 17 cycles.
    last_valid_s5 = -1;
    period_chk    = 1'b1;
    start         = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bin = 16'($urandom);
      wait_ready();
      @(posedge clk); #1;
      push_exp(bin);
    end
    start = 1'b0;
    wait_idle();
    period_chk = 1'b0;

    // Reset mid-conversion: 5 cycles after accept.
    send(16'd31415);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(q_s5.pop_back());
    void'(q_u5.pop_back());
    void'(q_u3.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("abort");
    @(posedge clk); #1;
    check("abort_ready_after", 32'(rdy_s5), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check_reset_vals("abort_hold");
    send(16'd2718); wait_idle();

    // Randomized values.
    for (int k = 0; k < 30; k++) begin
      send(16'($urandom));
      wait_idle();
    end

    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Multi-cycle, parametrised binary-to-BCD converter for the display path. It converts one WIDTH-bit value per request with a serial double-dabble datapath, one shift per clock. Signed inputs are handled as sign plus magnitude, and the block also reports leading-zero blanking and overflow. It sits between the arithmetic core and the seven-segment digit drivers, where a wide input would make the combinational converter too slow to close timing.

## Interface
- WIDTH, 16, width of the binary input; minimum 2.
- DIGITS, 5, number of BCD output digits.
- SIGNED, 1, 1 = input is two's complement; 0 = input is unsigned.
- clk  in  1  sole clock; all logic is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only while ready=1.
- bin  in  WIDTH  value to convert; sampled on the accepting edge only.
- ready  out  1  block is idle and can accept start.
- valid  out  1  one-cycle pulse marking a new result.
- bcd  out  4*DIGITS  result; digit i is bcd[4i+3:4i], digit 0 is least significant.
- bcd_sgn  out  4  sign code: 4'b1010 (minus) or 4'b1111 (blank).
- blank  out  DIGITS  bit i = 1 if digit i is a leading zero.
- ovf  out  1  result did not fit in DIGITS digits.

## Operation
- States: IDLE and CONV.
- Reset values:
  - state = IDLE, ready = 1, valid = 0.
  - bcd = 0, bcd_sgn = 4'b1111, ovf = 0.
  - blank = all ones except bit 0, which is 0.
- Accepting a request (IDLE with start=1):
  - Capture the magnitude: if SIGNED=1 and bin[WIDTH-1]=1, magnitude = -bin modulo 2^WIDTH; otherwise magnitude = bin.
  - The magnitude is treated as unsigned, so the most negative input (e.g. 16'h8000) gives magnitude 2^(WIDTH-1) exactly.
  - Latch the pending sign: 4'b1010 if negative, else 4'b1111. The sign is always 4'b1111 when SIGNED=0.
  - Clear the working BCD register and the overflow accumulator, load the bit counter with WIDTH, and go to CONV.
- Each CONV cycle:
  1. Add 3 to every working digit whose value is 5 or more. This is done on all digits in parallel, before the shift.
  2. Shift {working BCD, magnitude} left by one. The magnitude MSB enters BCD bit 0.
  3. If the bit shifted out of BCD bit 4*DIGITS-1 is 1, set the overflow accumulator.
  4. Decrement the counter.
- After the WIDTH-th shift:
  - Load bcd from the working register, bcd_sgn from the pending sign and ovf from the accumulator.
  - Compute blank from the loaded bcd.
  - Assert valid for one cycle and return to IDLE.
- Blanking rule:
  - blank[i] = 1 if digit i and every higher digit are zero.
  - blank[0] is always 0, so a result of zero shows a single "0".
  - When ovf=1, blank is all zeros.
- Hold behaviour:
  - bcd, bcd_sgn, blank and ovf hold their value until the next valid pulse.
  - They do not change during CONV.
- start is ignored while ready=0. Such a request is dropped, not queued.
- bin may change at any time after the accepting edge without affecting the conversion in progress.

## Timing
- Accept edge E0: the first rising edge with ready=1 and start=1. ready falls after E0.
- Shifts occur on edges E1 through EWIDTH. At EWIDTH the outputs update, valid rises and ready rises.
- Result latency: WIDTH cycles from the accept edge to valid high. ready is low for exactly WIDTH cycles.
- Back-to-back requests:
  - start held high through the valid cycle is accepted on the edge that ends that cycle.
  - Throughput is one result per WIDTH+1 cycles.
- Reset behaviour:
  - rst=1 wins over start on the same edge.
  - rst mid-conversion aborts the conversion: no valid pulse, all outputs go to their reset values, and ready=1 on the following cycle.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset, then unsigned max: WIDTH=16, SIGNED=0, bin=16'hFFFF.
  - Expect valid exactly 16 cycles after the accept edge.
  - Digits 4..0 = 6,5,5,3,5; bcd_sgn=4'b1111; blank=5'b00000; ovf=0.
- Signed minimum: SIGNED=1, bin=16'h8000.
  - Expect digits 3,2,7,6,8 and bcd_sgn=4'b1010.
  - Then bin=16'hFFFF: expect digit 0 = 1, blank=5'b11110, bcd_sgn=4'b1010.
- Zero and blanking: bin=0.
  - Expect bcd=0, blank=5'b11110, bcd_sgn=4'b1111.
  - Then bin=16'd407: expect digits 0,0,4,0,7 and blank=5'b11000 (the inner zero is not blanked).
- Overflow: WIDTH=16, DIGITS=3, SIGNED=0, bin=16'd1234.
  - Expect ovf=1 and blank=3'b000.
  - Then bin=16'd999: expect ovf=0 and digits 9,9,9.
- Handshake:
  - Pulse start mid-conversion with a different bin: the result equals the first value only, with a single valid pulse.
  - Hold start high continuously: valid pulses every 17 cycles.
- Reset mid-conversion: assert rst 5 cycles after accept.
  - Expect no valid pulse and all outputs at reset values.
  - ready=1 the cycle after rst drops; a new start then converts correctly.
